// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register.
// Performs the data-memory access for loads and stores arriving from EX/MEM,
// registers the write-back data for the register file, and serves a
// low-priority host port that only gets the memory when the pipeline is idle.
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  // From EX/MEM
  input  logic                      w_reg_en,
  input  logic                      w_mem_en,
  input  logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     r1_out,
  input  logic [DATA_WIDTH-1:0]     r2_out,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_1,
  // Host port
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [MEM_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic                      host_ack,
  output logic [DATA_WIDTH-1:0]     host_rdata,
  output logic                      host_rvalid,
  // To register file
  output logic                      w_reg_en_o,
  output logic [REG_ADDR_WIDTH-1:0] w_reg_1_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  // Data memory storage
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Registered outputs
  logic                      w_reg_en_q,  w_reg_en_d;
  logic [REG_ADDR_WIDTH-1:0] w_reg_1_q,   w_reg_1_d;
  logic [DATA_WIDTH-1:0]     wb_data_q,   wb_data_d;
  logic                      host_ack_q,  host_ack_d;
  logic                      host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0]     host_rdata_q,  host_rdata_d;

  // Arbitration and the single shared memory port
  logic                      pipe_mem_op;
  logic                      host_grant;
  logic [MEM_ADDR_WIDTH-1:0] pipe_addr;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Upper address bits are dropped so pipeline addresses wrap modulo depth.
  assign pipe_addr   = r1_out[MEM_ADDR_WIDTH-1:0];
  assign pipe_mem_op = w_mem_en | mem_rd_en;
  // host_ack_q gates the grant so every host access spends one cycle in ack.
  assign host_grant  = host_req & ~pipe_mem_op & ~host_ack_q;

  // Steer the single memory port to the pipeline or the granted host access.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mem_addr  = pipe_addr;
    mem_we    = 1'b0;
    mem_wdata = r2_out;
    if (pipe_mem_op) begin
      mem_addr  = pipe_addr;
      mem_we    = w_mem_en;
      mem_wdata = r2_out;
    end else if (host_grant) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end
  end

  // Read data is the pre-edge content; it is captured into registers below.
  assign mem_rdata = mem_q[mem_addr];

  // Next-state for the write-back register and the host response.
  always_comb begin
    w_reg_en_d    = w_reg_en;
    w_reg_1_d     = w_reg_1;
    wb_data_d     = r1_out;
    host_ack_d    = host_grant;
    host_rvalid_d = host_grant & ~host_we;
    host_rdata_d  = host_rdata_q;
    // Store+load together is write-first, so the stored value is forwarded.
    if (w_mem_en && mem_rd_en) begin
      wb_data_d = r2_out;
    end else if (mem_rd_en) begin
      wb_data_d = mem_rdata;
    end
    if (host_grant && !host_we) begin
      host_rdata_d = mem_rdata;
    end
  end

  // Memory array write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    // NOTE: memory has no reset branch so it can map onto a RAM macro.
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Pipeline and host response registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      w_reg_en_q    <= 1'b0;
      w_reg_1_q     <= '0;
      wb_data_q     <= '0;
      host_ack_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      w_reg_en_q    <= w_reg_en_d;
      w_reg_1_q     <= w_reg_1_d;
      wb_data_q     <= wb_data_d;
      host_ack_q    <= host_ack_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign w_reg_en_o  = w_reg_en_q;
  assign w_reg_1_o   = w_reg_1_q;
  assign wb_data_o   = wb_data_q;
  assign host_ack    = host_ack_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  localparam int DW = 64;
  localparam int RW = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_reg_en, w_mem_en, mem_rd_en;
  logic [DW-1:0] r1_out, r2_out;
  logic [RW-1:0] w_reg_1;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          w_reg_en_o;
  logic [RW-1:0] w_reg_1_o;
  logic [DW-1:0] wb_data_o;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .MEM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_reg_en   (w_reg_en),
    .w_mem_en   (w_mem_en),
    .mem_rd_en  (mem_rd_en),
    .r1_out     (r1_out),
    .r2_out     (r2_out),
    .w_reg_1    (w_reg_1),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .w_reg_en_o (w_reg_en_o),
    .w_reg_1_o  (w_reg_1_o),
    .wb_data_o  (wb_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_reg_en  = 1'b0;
    w_mem_en  = 1'b0;
    mem_rd_en = 1'b0;
    r1_out    = '0;
    r2_out    = '0;
    w_reg_1   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"},   DW'(w_reg_en_o),  '0);
    check({tag, "_wreg"},   DW'(w_reg_1_o),   '0);
    check({tag, "_wb"},     wb_data_o,        '0);
    check({tag, "_ack"},    DW'(host_ack),    '0);
    check({tag, "_rvalid"}, DW'(host_rvalid), '0);
    check({tag, "_rdata"},  host_rdata,       '0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #1 check_all_zero("rst_async");
    step();
    step();
    reset = 1'b0;
    step();
    check_all_zero("rst_idle");

    // ALU pass-through
    w_reg_en = 1'b1; w_reg_1 = 3'd5; r1_out = 64'h1234;
    step();
    check("alu_wren", DW'(w_reg_en_o), 64'd1);
    check("alu_wreg", DW'(w_reg_1_o),  64'd5);
    check("alu_wb",   wb_data_o,       64'h1234);

    // Store then load of the same address
    idle(); w_mem_en = 1'b1; r1_out = 64'd3; r2_out = 64'hDEADBEEF;
    step();
    idle(); mem_rd_en = 1'b1; w_reg_en = 1'b1; r1_out = 64'd3; w_reg_1 = 3'd2;
    step();
    check("ld_wb",   wb_data_o,       64'hDEADBEEF);
    check("ld_wreg", DW'(w_reg_1_o),  64'd2);
    check("ld_wren", DW'(w_reg_en_o), 64'd1);

    // Wrapped store address 0x103 lands in word 3; host reads it back
    idle(); w_mem_en = 1'b1; r1_out = 64'h103; r2_out = 64'hCAFE;
    step();
    idle(); host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    step();
    check("wrap_ack",    DW'(host_ack),    64'd1);
    check("wrap_rvalid", DW'(host_rvalid), 64'd1);
    check("wrap_rdata",  host_rdata,       64'hCAFE);
    host_req = 1'b0;
    step();
    check("wrap_ack_drop",    DW'(host_ack),    64'd0);
    check("wrap_rvalid_drop", DW'(host_rvalid), 64'd0);
    check("wrap_rdata_hold",  host_rdata,       64'hCAFE);

    // Store and load together: write-first forwarding, then read back
    w_mem_en = 1'b1; mem_rd_en = 1'b1; r1_out = 64'd5; r2_out = 64'hA5;
    step();
    check("stld_wb", wb_data_o, 64'hA5);
    idle(); mem_rd_en = 1'b1; r1_out = 64'd5;
    step();
    check("stld_mem", wb_data_o, 64'hA5);

    // Host write starved by three loads, then granted on the first idle cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd7; host_wdata = 64'h77;
    idle(); mem_rd_en = 1'b1; r1_out = 64'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("starve_ack%0d", i), DW'(host_ack), 64'd0);
    end
    idle();
    step();
    check("hwr_ack",    DW'(host_ack),    64'd1);
    check("hwr_rvalid", DW'(host_rvalid), 64'd0);
    host_req = 1'b0;
    step();
    check("hwr_ack_once", DW'(host_ack), 64'd0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd7;
    step();
    check("hrd_ack",    DW'(host_ack),    64'd1);
    check("hrd_rvalid", DW'(host_rvalid), 64'd1);
    check("hrd_rdata",  host_rdata,       64'h77);
    host_req = 1'b0;
    step();

    // Host request held high across idle cycles: grants on alternate edges
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    check("hold_ack0", DW'(host_ack), 64'd0);
    step(); check("hold_ack1", DW'(host_ack), 64'd1);
    step(); check("hold_ack2", DW'(host_ack), 64'd0);
    step(); check("hold_ack3", DW'(host_ack), 64'd1);
    step(); check("hold_ack4", DW'(host_ack), 64'd0);
    host_req = 1'b0;
    step();

    // Reset in the ack cycle of a host write: ack is killed, data survives
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd9; host_wdata = 64'h99;
    w_reg_en = 1'b1; w_reg_1 = 3'd4; r1_out = 64'h55;
    step();
    check("pre_rst_ack", DW'(host_ack), 64'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    host_req = 1'b0; idle();
    #2 reset = 1'b0;
    step();
    check("post_rst_ack", DW'(host_ack), 64'd0);
    mem_rd_en = 1'b1; r1_out = 64'd9;
    step();
    check("post_rst_mem", wb_data_o, 64'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
